// File: rtl/hex_digit_scanner_if.sv
// Display bus between the value producer and the seven-segment scanner.
// master: drives the value/decimal-point/load side and observes the pins.
// slave : the scanner, which consumes the value and drives the digit pins.
interface hex_digit_scanner_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic [DIGITS-1:0]   sel;
  logic [6:0]          seg;
  logic                dp_out;
  logic                frame_done;

  modport master (output data, dp, load, input sel, seg, dp_out, frame_done);
  modport slave  (input data, dp, load, output sel, seg, dp_out, frame_done);
endinterface

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed common-anode seven-segment driver.
// A prescaler tick advances the digit index; the tick edge blanks all anodes
// (dead cycle) while loading the new digit's segments, and the following
// edge enables that digit's anode. All outputs are registered and active low.
// Optional build macro HEX_DIGIT_SCANNER_LZ_BLANK_EN: blank leading zero
// digits (index >= 1 whose nibble and all more-significant nibbles are 0).
module hex_digit_scanner #(
  parameter int DIGITS   = 4,
  parameter int DIV_BITS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hex_digit_scanner_if.slave bus
);
  localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  logic [DIV_BITS-1:0] pre;
  logic [IW-1:0]       idx, nidx;
  logic                tick, pend;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_dp;
  logic [3:0]          nib [DIGITS];
  logic [6:0]          seg_nx;
  logic [DIGITS-1:0]   sel_q;
  logic [6:0]          seg_q;
  logic                dp_q, fd_q;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  assign tick = &pre;
  assign nidx = (idx == LAST) ? '0 : idx + IW'(1);

  for (genvar i = 0; i < DIGITS; i++) begin : g_nib
    assign nib[i] = sh_data[4*i +: 4];
  end

`ifdef HEX_DIGIT_SCANNER_LZ_BLANK_EN
  // lz[k]: digit k is a leading zero (itself and everything above is zero)
  logic [DIGITS-1:0] lz;
  assign lz[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_lz
    assign lz[k] = (sh_data[4*DIGITS-1:4*k] == '0);
  end

  // Pattern for the digit about to be shown, with leading-zero blanking
  always_comb begin
    seg_nx = decode(nib[nidx]);
    if (lz[nidx]) seg_nx = 7'h7F;
  end
`else
  // Pattern for the digit about to be shown
  always_comb begin
    seg_nx = decode(nib[nidx]);
  end
`endif

  // Prescaler, digit index and registered pin drivers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre   <= '0;
      idx   <= LAST;
      pend  <= 1'b0;
      sel_q <= '1;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      fd_q  <= 1'b0;
    end else begin
      pre  <= pre + DIV_BITS'(1);
      pend <= tick;
      fd_q <= tick && (nidx == '0);
      if (tick) begin
        // dead cycle: anodes off while segments settle to the new digit
        idx   <= nidx;
        sel_q <= '1;
        seg_q <= seg_nx;
        dp_q  <= ~sh_dp[nidx];
      end else if (pend) begin
        sel_q <= ~(DIGITS'(1) << idx);
      end
    end
  end

  // Shadow capture; a tick on the same edge still sees the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_data <= '0;
      sh_dp   <= '0;
    end else if (bus.load) begin
      sh_data <= bus.data;
      sh_dp   <= bus.dp;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.seg        = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// Self-checking bench: a 4-digit/DIV_BITS=2 scanner and a 1-digit/DIV_BITS=1
// scanner, compared against an edge-count model of the display behaviour.
module tb_hex_digit_scanner;
  logic clk, rst_n;
  int   total, bad;

  hex_digit_scanner_if #(.DIGITS(4)) bus0 ();
  hex_digit_scanner_if #(.DIGITS(1)) bus1 ();

  hex_digit_scanner #(.DIGITS(4), .DIV_BITS(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  hex_digit_scanner #(.DIGITS(1), .DIV_BITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

`ifdef HEX_DIGIT_SCANNER_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  // Model: n = edges since reset release; shadow and the shadow seen by the last tick
  int         n;
  logic [15:0] m_sh, s_sh;
  logic [3:0]  m_dp, s_dp;

  always @(posedge clk) begin
    if (!rst_n) begin
      n    <= 0;
      m_sh <= '0;
      m_dp <= '0;
    end else begin
      n <= n + 1;
      if ((n + 1) % 4 == 0) begin
        s_sh <= m_sh;
        s_dp <= m_dp;
      end
      if (bus0.load) begin
        m_sh <= bus0.data;
        m_dp <= bus0.dp;
      end
    end
  end

  // Expected {sel(4, unused upper bits 1), seg, dp_out, frame_done} after n edges
  function automatic logic [12:0] expect_out(input int D, input int P, input int en,
                                             input logic [15:0] sd, input logic [3:0] sdp);
    int k, i;
    logic dead, blank;
    logic [3:0] s;
    logic [15:0] sh;
    k = en / P;
    if (k == 0) return {4'hF, 7'h7F, 1'b1, 1'b0};
    i    = (k - 1) % D;
    dead = (en % P) == 0;
    s    = dead ? 4'hF : ~(4'b0001 << i);
    sh   = sd >> (4 * i);
    blank = LZ && (i >= 1) && (sh == 16'h0);
    return {s, blank ? 7'h7F : SEGTAB[sh[3:0]], ~sdp[i], dead && (i == 0)};
  endfunction

  task automatic test_reset();
    logic [12:0] e, g;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      g = {bus0.sel, bus0.seg, bus0.dp_out, bus0.frame_done};
      total++;
      if (g !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        bad++; $display("FAIL reset got=%h want=%h", g, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      e = expect_out(4, 4, n, s_sh, s_dp);
      g = {bus0.sel, bus0.seg, bus0.dp_out, bus0.frame_done};
      total++;
      if (g !== e) begin bad++; $display("FAIL first_scan n=%0d got=%h want=%h", n, g, e); end
      if (n == 4) begin
        total++;
        if ({bus0.sel, bus0.frame_done} !== {4'hF, 1'b1}) begin
          bad++; $display("FAIL first_tick sel=%h fd=%b want F/1", bus0.sel, bus0.frame_done);
        end
      end
      if (n == 5) begin
        total++;
        if ({bus0.sel, bus0.seg} !== {4'hE, 7'h40}) begin
          bad++; $display("FAIL digit0_visible sel=%h seg=%h want E/40", bus0.sel, bus0.seg);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    logic [12:0] e, g;
    int pulses;
    @(negedge clk);
    bus0.data = 16'hA3F8; bus0.dp = 4'b0100; bus0.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
    repeat (16) @(negedge clk);
    pulses = 0;
    repeat (32) begin
      @(negedge clk);
      e = expect_out(4, 4, n, s_sh, s_dp);
      g = {bus0.sel, bus0.seg, bus0.dp_out, bus0.frame_done};
      total++;
      if (g !== e) begin bad++; $display("FAIL frame n=%0d got=%h want=%h", n, g, e); end
      if (bus0.frame_done) pulses++;
      if (bus0.sel != 4'hF) begin
        total++;
        if (bus0.dp_out !== (bus0.sel != 4'hB) ||
            bus0.seg !== (bus0.sel == 4'hE ? 7'h00 : bus0.sel == 4'hD ? 7'h0E :
                          bus0.sel == 4'hB ? 7'h30 : 7'h08)) begin
          bad++; $display("FAIL frame_digit sel=%h seg=%h dp=%b", bus0.sel, bus0.seg, bus0.dp_out);
        end
      end
    end
    total++;
    if (pulses !== 2) begin bad++; $display("FAIL frame_pulses got=%0d want=2", pulses); end
  endtask

  task automatic test_load_collision();
    logic [12:0] e, g;
    int guard;
    @(negedge clk);
    bus0.data = 16'h1111; bus0.dp = 4'b0000; bus0.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
    repeat (20) @(negedge clk);
    guard = 0;
    while (n % 4 != 3 && guard < 8) begin @(negedge clk); guard++; end
    bus0.data = 16'h2222; bus0.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
    total++;
    if (bus0.seg !== 7'h79) begin bad++; $display("FAIL collide_old seg=%h want=79", bus0.seg); end
    repeat (4) @(negedge clk);
    total++;
    if (bus0.seg !== 7'h24) begin bad++; $display("FAIL collide_new seg=%h want=24", bus0.seg); end
    repeat (20) begin
      @(negedge clk);
      e = expect_out(4, 4, n, s_sh, s_dp);
      g = {bus0.sel, bus0.seg, bus0.dp_out, bus0.frame_done};
      total++;
      if (g !== e) begin bad++; $display("FAIL collide_scan n=%0d got=%h want=%h", n, g, e); end
    end
  endtask

  task automatic test_random();
    logic [12:0] e, g;
    repeat (300) begin
      @(negedge clk);
      e = expect_out(4, 4, n, s_sh, s_dp);
      g = {bus0.sel, bus0.seg, bus0.dp_out, bus0.frame_done};
      total++;
      if (g !== e) begin bad++; $display("FAIL random n=%0d got=%h want=%h", n, g, e); end
      bus0.data = 16'($urandom);
      bus0.dp   = 4'($urandom);
      bus0.load = ($urandom_range(0, 5) == 0);
    end
    bus0.load = 1'b0;
  endtask

  task automatic test_blanking();
    logic [6:0] want;
    @(negedge clk);
    bus0.data = 16'h0070; bus0.dp = 4'b0000; bus0.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
    repeat (16) @(negedge clk);
    repeat (16) begin
      @(negedge clk);
      if (bus0.sel != 4'hF) begin
        want = (bus0.sel == 4'hE) ? 7'h40 : (bus0.sel == 4'hD) ? 7'h78 : (LZ ? 7'h7F : 7'h40);
        total++;
        if (bus0.seg !== want) begin
          bad++; $display("FAIL blank sel=%h seg=%h want=%h", bus0.sel, bus0.seg, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e, g;
    logic [6:0] want;
    int guard;
    @(negedge clk);
    bus0.data = 16'h5678; bus0.dp = 4'b1111; bus0.load = 1'b1;
    @(negedge clk);
    bus0.load = 1'b0;
    guard = 0;
    while (bus0.sel !== 4'hD && guard < 64) begin @(negedge clk); guard++; end
    total++;
    if (guard >= 64) begin bad++; $display("FAIL mid_wait sel=%h never reached D", bus0.sel); end
    rst_n = 1'b0;
    @(negedge clk);
    g = {bus0.sel, bus0.seg, bus0.dp_out, bus0.frame_done};
    total++;
    if (g !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      bad++; $display("FAIL mid_reset got=%h want=%h", g, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    rst_n = 1'b1;
    repeat (24) begin
      @(negedge clk);
      e = expect_out(4, 4, n, s_sh, s_dp);
      g = {bus0.sel, bus0.seg, bus0.dp_out, bus0.frame_done};
      total++;
      if (g !== e) begin bad++; $display("FAIL mid_scan n=%0d got=%h want=%h", n, g, e); end
      if (bus0.sel != 4'hF) begin
        want = (bus0.sel == 4'hE || !LZ) ? 7'h40 : 7'h7F;
        total++;
        if (bus0.seg !== want || bus0.dp_out !== 1'b1) begin
          bad++; $display("FAIL mid_zero sel=%h seg=%h dp=%b want %h/1", bus0.sel, bus0.seg, bus0.dp_out, want);
        end
      end
    end
  endtask

  task automatic test_single_digit();
    logic [12:0] e, g;
    logic prev;
    int pulses;
    pulses = 0;
    @(negedge clk);
    prev = bus1.sel[0];
    repeat (12) begin
      @(negedge clk);
      e = expect_out(1, 2, n, 16'h0007, 4'h1);
      g = {3'b111, bus1.sel, bus1.seg, bus1.dp_out, bus1.frame_done};
      total++;
      if (g !== e) begin bad++; $display("FAIL single n=%0d got=%h want=%h", n, g, e); end
      total++;
      if (bus1.sel[0] === prev) begin bad++; $display("FAIL single_alt sel=%b prev=%b", bus1.sel, prev); end
      prev = bus1.sel[0];
      if (bus1.frame_done) pulses++;
    end
    total++;
    if (pulses !== 6) begin bad++; $display("FAIL single_pulses got=%0d want=6", pulses); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus0.data = '0; bus0.dp = '0; bus0.load = 1'b0;
    bus1.data = 4'h7; bus1.dp = 1'b1; bus1.load = 1'b1;
    test_reset();
    test_full_frame();
    test_load_collision();
    test_random();
    test_blanking();
    test_reset_mid();
    test_single_digit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hex_digit_scanner.md
# hex_digit_scanner

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It holds a shadow copy of a packed hex value and a decimal-point mask, refreshes one digit at a time at a prescaled rate, and decodes each nibble to active-low segment patterns. One-cycle anode dead time at every digit change prevents ghosting. It sits between the display-value producer and the IO-shield digit/segment pins.

## Interface
- DIGITS, 4, number of digits scanned (≥1); digit DIGITS-1 is the most significant nibble
- DIV_BITS, 16, prescaler width; digit period is 2^DIV_BITS cycles (≥1)
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- data  in  4*DIGITS  packed nibbles; digit i = data[4i+3:4i]
- dp  in  DIGITS  decimal-point request per digit, 1 = lit
- load  in  1  when high at an edge, data and dp are captured into the shadow registers
- sel  out  DIGITS  active-low one-hot digit anode select; all ones = all off
- seg  out  7  active-low segments, bit0 = a … bit6 = g
- dp_out  out  1  active-low decimal point for the selected digit
- frame_done  out  1  one-cycle pulse marking the start of a new scan frame

## Operation
- Reset values: prescaler 0, digit index DIGITS-1, shadow data 0, shadow dp 0, sel all ones, seg 7'h7F, dp_out 1, frame_done 0.
- The prescaler increments every cycle and wraps. A tick occurs in the cycle where the prescaler is all ones.
- On a tick edge:
  - the index advances (DIGITS-1 wraps to 0);
  - sel is driven all ones for the dead cycle;
  - seg and dp_out load the decoded pattern for the new index from the shadow registers;
  - frame_done is 1 if the new index is 0, otherwise 0.
- On the edge after the tick edge, sel becomes one-hot low at bit index, and frame_done returns to 0.
- seg, dp_out and sel hold their values between updates.
- Segment code (g..a, active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- load is independent of the scan. The shadow registers update on any edge where load is high.
- If load and a tick coincide, the tick decodes the old shadow value. The new value appears from the next tick onward.
- With DIGITS=1: the index stays 0. Every tick still produces a dead cycle and a frame_done pulse.
- If rst_n goes low mid-scan, every register returns to its reset value on that edge, regardless of other inputs.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- Scan cycle per digit:
  - tick edge: sel all ones, seg/dp_out show the new digit;
  - tick+1 edge: sel selects the digit for the remaining 2^DIV_BITS−1 cycles.
- After reset release, the first tick occurs 2^DIV_BITS cycles later. Digit 0 is visible one cycle after that, and sel stays all ones until then.
- load → visible: at most DIGITS digit periods + 1 cycle; at least 2 cycles (load edge, then the following tick edge at the earliest).
- Frame period: DIGITS × 2^DIV_BITS cycles. frame_done is high for exactly 1 cycle per frame.

## Configuration
- HEX_DIGIT_SCANNER_LZ_BLANK_EN
  - Defined: a digit with index ≥1 is blanked (seg 7'h7F) when its shadow nibble and all more-significant nibbles are zero. Digit 0 is never blanked. dp_out still follows shadow dp, and sel and the dead cycle are unchanged.
  - Undefined: every digit shows its decoded nibble.

## Test plan
- Reset, then scan: DIGITS=4, DIV_BITS=2, hold rst_n low 3 cycles, release.
  - sel=4'hF, seg=7'h7F, dp_out=1 until the first tick (4 cycles).
  - After the first tick: sel=4'hF for 1 cycle, then 4'hE with seg=7'h40.
- Full frame: load data=16'hA3F8, dp=4'b0100.
  - Digits 0..3 show seg 00, 0E, 30, 08.
  - dp_out=0 only while sel=4'hB.
  - frame_done pulses once per 16 cycles, in the dead cycle before digit 0.
- Load colliding with a tick: data changes 16'h1111→16'h2222 with load high on a tick cycle.
  - That digit still shows 79.
  - The next digit shows 24.
- Reset mid-scan: rst_n low for 1 cycle while sel=4'hD.
  - Next edge: sel=4'hF, seg=7'h7F, frame_done=0.
  - Shadow is 0, so the display reads 0000, or only digit 0 lit (40) with LZ_BLANK_EN.
- Blanking with HEX_DIGIT_SCANNER_LZ_BLANK_EN defined, data=16'h0070:
  - digits 3 and 2 show 7F;
  - digit 1 shows 78;
  - digit 0 shows 40.
  - Without the macro, digits 3 and 2 show 40.
- DIGITS=1, DIV_BITS=1: sel alternates 1'b1, 1'b0 every cycle, and frame_done pulses every 2 cycles.
